uart_bus_bridge: RTL
====================

// Module: uart_bus_bridge
// PURPOSE
//  Host-side debug/loader bridge: consumes a UART byte stream from the host PC, decodes command frames and,
//  acting as a data-bus initiator, issues 32-bit word reads/writes on the data memory / IO address map.
//  Sends acknowledge or read-data bytes back as a UART byte stream. Sits between the UART byte PHY and
//  the data-bus arbiter, peer of the processor data port. Allows program/data load and peripheral poking
//  without the CPU.
// PARAMETERS
//  TIMEOUT_CYCLES  1_000_000  max idle clk cycles between bytes of one frame before the frame is aborted
//  ACK_WAIT        16         max clk cycles from bus_req assertion to bus_ack before bus error
// PORTS
//  clk        in   1   single clock; all logic on rising edge
//  reset      in   1   asynchronous, active-low reset
//  rx_data    in   8   byte received from host
//  rx_valid   in   1   1-cycle strobe, rx_data valid
//  tx_data    out  8   byte to send to host
//  tx_valid   out  1   tx_data valid; held until accepted
//  tx_ready   in   1   PHY accepts tx_data when tx_valid&&tx_ready
//  bus_req    out  1   bus access request; held until bus_ack
//  bus_we     out  1   1=write, 0=read; valid with bus_req
//  bus_addr   out  32  word address, [1:0] forced 2'b00
//  bus_wdata  out  32  write data
//  bus_rdata  in   32  read data, sampled in bus_ack cycle
//  bus_ack    in   1   1-cycle completion strobe
//  busy       out  1   1 whenever state != IDLE
//  overrun    out  1   sticky: rx byte arrived while not accepting (BUS/RESP); cleared only by reset
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, all counters 0, tx_valid=0, tx_data=0, bus_req=0, bus_we=0,
//   bus_addr=0, bus_wdata=0, busy=0, overrun=0. Reset mid-frame/mid-access drops everything; no bus retry.
//  Frames (multi-byte fields LSB first):
//   WRITE: 0x57, A0..A3, D0..D3 -> one bus write -> response 0x4B.
//   READ : 0x52, A0..A3         -> one bus read  -> response R0..R3 (bus_rdata LSB first).
//   other cmd byte -> response 0x3F, no bus access.
//  FSM: IDLE -(rx 0x57/0x52)-> ADDR; -(rx other)-> RESP with 1-byte 0x3F.
//   ADDR: collect 4 bytes (idx 0..3) -> DATA if write, else BUS. DATA: collect 4 bytes -> BUS.
//   BUS: bus_req=1 from first BUS cycle until bus_ack cycle inclusive; bus_ack -> RESP; read latches bus_rdata.
//   RESP: emit N bytes (1 for write/unknown/error, 4 for read) -> IDLE after last handshake.
//  Latency: bus_req asserts the cycle after the last frame byte strobe; RESP tx_valid the cycle after bus_ack.
//  tx handshake: tx_data/tx_valid stable while tx_valid&&!tx_ready; next byte presented the cycle after accept;
//   no combinational path tx_ready->tx_valid.
//  Inter-byte timeout: counter reloads on every rx_valid in ADDR/DATA; reaching TIMEOUT_CYCLES -> IDLE,
//   no bus access, no response. Timer inactive in IDLE/BUS/RESP.
//  Bus timeout: no bus_ack within ACK_WAIT cycles of bus_req rise -> drop bus_req, RESP with 1-byte 0x45.
//  rx_valid in BUS/RESP: byte discarded, overrun<=1. rx_valid in IDLE/ADDR/DATA always accepted.
//  bus_ack outside BUS: ignored. Simultaneous rx_valid and timer expiry: byte wins (timer reloads).
//  Byte/word counters are 2-bit, wrap 3->0 only on state exit; assembled addr/data are 32-bit shift regs.
// STRUCTURE
//  Package uart_bridge_pkg: state enum (IDLE, ADDR, DATA, BUS, RESP); byte constants CMD_WR=8'h57,
//   CMD_RD=8'h52, RSP_OK=8'h4B, RSP_BAD=8'h3F, RSP_BUSERR=8'h45.
//  One sub-module: uart_bridge_timer (loadable down-counter, reload/enable in, expired out), instanced
//   twice (inter-byte timeout, bus-ack timeout). FSM, shift regs and tx mux stay in this module.
// TESTING
//  1 rx 57 10 00 00 00 EF BE AD DE, bus_ack 2 cycles after req -> one req, we=1, addr=0x10,
//    wdata=0xDEADBEEF; tx 4B.
//  2 rx 52 13 00 00 00, bus_rdata=0xCAFEF00D at ack -> we=0, addr=0x10 (low bits cleared); tx 0D F0 FE CA.
//  3 rx 41 -> tx 3F, bus_req never asserts, busy back to 0 after handshake.
//  4 rx 57 10 00 then silence TIMEOUT_CYCLES -> IDLE, no req, no tx; following READ frame completes normally.
//  5 READ frame, bus_ack never -> bus_req low after ACK_WAIT cycles, tx 45; tx_ready low 100 cycles during
//    READ response -> tx_data/tx_valid unchanged; rx byte during RESP -> overrun=1.
//  6 reset low mid-RESP after 2 of 4 bytes -> tx_valid=0 and bus_req=0 immediately; after release,
//    WRITE frame works.

Source files
------------

// File: rtl/uart_bus_bridge_pkg.sv
// Shared types and byte constants for the UART-to-bus debug/loader bridge.
package uart_bridge_pkg;

    // Frame-decoder states
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        RESP
    } state_e;

    // Host command bytes
    localparam logic [7:0] CMD_WR     = 8'h57;
    localparam logic [7:0] CMD_RD     = 8'h52;

    // Response bytes
    localparam logic [7:0] RSP_OK     = 8'h4B;
    localparam logic [7:0] RSP_BAD    = 8'h3F;
    localparam logic [7:0] RSP_BUSERR = 8'h45;

    // Bus accesses are always word aligned
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/uart_bus_bridge_if.sv
// UART byte stream and data-bus signals of the bridge, plus status outputs.
// master: the bridge itself; slave: the UART PHY / bus arbiter side.
interface uart_bus_bridge_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        busy;
    logic        overrun;

    modport master (
        input  rx_data, rx_valid, tx_ready, bus_rdata, bus_ack,
        output tx_data, tx_valid, bus_req, bus_we, bus_addr, bus_wdata, busy, overrun
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, bus_rdata, bus_ack,
        input  tx_data, tx_valid, bus_req, bus_we, bus_addr, bus_wdata, busy, overrun
    );
endinterface

// File: rtl/uart_bridge_timer.sv
// Loadable down-counter. Counts down while enabled, saturates at zero;
// expired_o flags an enabled cycle in which the count has reached zero.
module uart_bridge_timer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LOAD_VAL = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [WIDTH-1:0] LOAD = WIDTH'(LOAD_VAL);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Reload has priority over counting
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_bus_bridge.sv
// Host debug/loader bridge: decodes UART command frames into 32-bit bus
// reads/writes and returns acknowledge or read-data bytes to the host.
module uart_bus_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned ACK_WAIT       = 16
) (
    input  logic              clk,
    input  logic              reset,
    uart_bus_bridge_if.master bif
);

    localparam int unsigned IB_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned ACK_W = $clog2(ACK_WAIT + 1);

    state_e      state_q,   state_d;
    logic [1:0]  idx_q,     idx_d;
    logic        we_q,      we_d;
    logic [31:0] addr_q,    addr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [31:0] resp_q,    resp_d;
    logic [1:0]  left_q,    left_d;
    logic        overrun_q, overrun_d;

    logic ib_load;
    logic ib_en;
    logic ib_expired;
    logic ack_load;
    logic ack_en;
    logic ack_expired;

    // Inter-byte timer: runs only while a frame is being collected
    assign ib_load = bif.rx_valid && ((state_q == IDLE) || (state_q == ADDR) || (state_q == DATA));
    assign ib_en   = (state_q == ADDR) || (state_q == DATA);

    // Ack timer: held at reload outside BUS so it starts full on BUS entry
    assign ack_load = (state_q != BUS);
    assign ack_en   = (state_q == BUS);

    uart_bridge_timer #(
        .WIDTH   (IB_W),
        .LOAD_VAL(TIMEOUT_CYCLES - 1)
    ) u_ib_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (ib_load),
        .en_i     (ib_en),
        .expired_o(ib_expired)
    );

    uart_bridge_timer #(
        .WIDTH   (ACK_W),
        .LOAD_VAL(ACK_WAIT - 1)
    ) u_ack_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (ack_load),
        .en_i     (ack_en),
        .expired_o(ack_expired)
    );

    // Next-state, shift registers and response selection
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        resp_d    = resp_q;
        left_d    = left_q;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (bif.rx_valid) begin
                    if ((bif.rx_data == CMD_WR) || (bif.rx_data == CMD_RD)) begin
                        state_d = ADDR;
                        we_d    = (bif.rx_data == CMD_WR);
                        idx_d   = '0;
                    end else begin
                        state_d = RESP;
                        resp_d  = {24'h0, RSP_BAD};
                        left_d  = '0;
                    end
                end
            end
            ADDR: begin
                // A byte arriving in the expiry cycle still counts
                if (bif.rx_valid) begin
                    addr_d = {bif.rx_data, addr_q[31:8]};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = we_q ? DATA : BUS;
                    end
                end else if (ib_expired) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (bif.rx_valid) begin
                    wdata_d = {bif.rx_data, wdata_q[31:8]};
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = BUS;
                    end
                end else if (ib_expired) begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                if (bif.rx_valid) begin
                    overrun_d = 1'b1;
                end
                // An ack in the last allowed cycle beats the timeout
                if (bif.bus_ack) begin
                    state_d = RESP;
                    if (we_q) begin
                        resp_d = {24'h0, RSP_OK};
                        left_d = '0;
                    end else begin
                        resp_d = bif.bus_rdata;
                        left_d = 2'd3;
                    end
                end else if (ack_expired) begin
                    state_d = RESP;
                    resp_d  = {24'h0, RSP_BUSERR};
                    left_d  = '0;
                end
            end
            RESP: begin
                if (bif.rx_valid) begin
                    overrun_d = 1'b1;
                end
                if (bif.tx_ready) begin
                    resp_d = {8'h00, resp_q[31:8]};
                    if (left_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        left_d = left_q - 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            resp_q    <= '0;
            left_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            resp_q    <= resp_d;
            left_q    <= left_d;
            overrun_q <= overrun_d;
        end
    end

    assign bif.bus_req   = (state_q == BUS);
    assign bif.bus_we    = we_q;
    assign bif.bus_addr  = word_align(addr_q);
    assign bif.bus_wdata = wdata_q;
    assign bif.tx_valid  = (state_q == RESP);
    assign bif.tx_data   = resp_q[7:0];
    assign bif.busy      = (state_q != IDLE);
    assign bif.overrun   = overrun_q;

endmodule
